// File: rtl/filt_decim_avg_pkg.sv
// Shared defaults and output-FSM encoding for the decimating averager.
package filt_decim_avg_pkg;
  localparam int NB_DATA_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;
endpackage

// File: rtl/filt_decim_avg_acc_dump_core.sv
// Accumulate-and-dump core: sums 2^DEC_LOG2 enabled samples, strobes dump with the floored mean.
import filt_decim_avg_pkg::*;

module acc_dump_core #(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int DEC_LOG2 = 2
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [NB_DATA-1:0] y,
  input  logic               en,
  output logic               dump,
  output logic [NB_DATA-1:0] result
);
  localparam int AW = NB_DATA + DEC_LOG2;

  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [DEC_LOG2-1:0] cnt;

  // Two's-complement add is sign-agnostic once y is sign-extended.
  assign sum  = acc + {{DEC_LOG2{y[NB_DATA-1]}}, y};
  assign dump = en && (cnt == '1);
  // Dropping the low DEC_LOG2 bits is an arithmetic shift (floor divide).
  assign result = sum[AW-1:DEC_LOG2];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;  // wraps to 0 on the dump edge
      acc <= dump ? '0 : sum;
    end
  end
endmodule

// File: rtl/filt_decim_avg.sv
// Decimate-by-2^DEC_LOG2 averager with a one-deep valid/ready output and sticky overrun.
import filt_decim_avg_pkg::*;

module filt_decim_avg #(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int DEC_LOG2 = 2
) (
  input  logic               clock,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_y,
  input  logic               i_en,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_overrun
);
  logic               dump;
  logic [NB_DATA-1:0] result;
  ostate_t            state, state_nxt;
  logic [NB_DATA-1:0] data_q, data_nxt;
  logic               ovr_q, ovr_nxt;

  acc_dump_core #(
    .NB_DATA (NB_DATA),
    .DEC_LOG2(DEC_LOG2)
  ) u_core (
    .clock (clock),
    .rst_n (i_rst_n),
    .y     (i_y),
    .en    (i_en),
    .dump  (dump),
    .result(result)
  );

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= EMPTY;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  // The filter is never stalled: a dump that finds the slot occupied is dropped.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    ovr_nxt   = ovr_q;
    case (state)
      EMPTY: begin
        if (dump) begin
          state_nxt = FULL;
          data_nxt  = result;
        end
      end
      FULL: begin
        if (i_ready) begin
          if (dump) data_nxt  = result;
          else      state_nxt = EMPTY;
        end else if (dump) begin
          ovr_nxt = 1'b1;
        end
      end
    endcase
  end

  assign o_data    = data_q;
  assign o_valid   = (state == FULL);
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_filt_decim_avg.sv
// Directed bench for filt_decim_avg with a block-level reference model and per-cycle compare.
module tb_filt_decim_avg;
  localparam int NB = 8;
  localparam int DL = 2;
  localparam int N  = 1 << DL;

  logic          clock = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [NB-1:0] i_y = '0;
  logic          i_en = 1'b0;
  logic          i_ready = 1'b0;
  logic [NB-1:0] o_data;
  logic          o_valid;
  logic          o_overrun;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  filt_decim_avg #(.NB_DATA(NB), .DEC_LOG2(DL)) dut (
    .clock    (clock),
    .i_rst_n  (i_rst_n),
    .i_y      (i_y),
    .i_en     (i_en),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_overrun(o_overrun)
  );

  always #5 clock = ~clock;

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: collect enabled samples into blocks; one-slot output buffer.
  int            blk_sum, blk_n, res;
  bit            m_dump, m_valid, m_ovr;
  logic [NB-1:0] m_data;

  always @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blk_sum = 0; blk_n = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    end else begin
      m_dump = 1'b0;
      res = 0;
      if (i_en) begin
        blk_sum = blk_sum + int'($signed(i_y));
        blk_n = blk_n + 1;
        if (blk_n == N) begin
          m_dump = 1'b1;
          res = floor_div(blk_sum, N);
          blk_sum = 0; blk_n = 0;
        end
      end
      if (!m_valid) begin
        if (m_dump) begin m_valid = 1'b1; m_data = res[NB-1:0]; end
      end else if (i_ready) begin
        if (m_dump) m_data = res[NB-1:0];
        else        m_valid = 1'b0;
      end else if (m_dump) begin
        m_ovr = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (started && i_rst_n) begin
      chk("model_valid", int'(o_valid), int'(m_valid));
      chk("model_overrun", int'(o_overrun), int'(m_ovr));
      chk("model_data", int'(o_data), int'(m_data));
    end
  end

  // Apply inputs, take one rising edge, return on the following falling edge.
  task automatic drive(input int y, input bit en, input bit rdy);
    i_y = y[NB-1:0]; i_en = en; i_ready = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_data", int'(o_data), 0);
    chk("reset_overrun", int'(o_overrun), 0);
    i_rst_n = 1'b1;
    started = 1'b1;

    // Basic block: 1,1,2,5 -> 2
    drive(1, 1, 1); drive(1, 1, 1); drive(2, 1, 1);
    chk("basic_not_yet", int'(o_valid), 0);
    drive(5, 1, 1);
    chk("basic_valid", int'(o_valid), 1);
    chk("basic_data", int'(o_data), 2);
    drive(0, 0, 1);
    chk("basic_drained", int'(o_valid), 0);

    // Negative floor: -11/4 -> -3
    drive(-3, 1, 1); drive(-3, 1, 1); drive(-3, 1, 1); drive(-2, 1, 1);
    chk("neg_valid", int'(o_valid), 1);
    chk("neg_data", int'(o_data), 8'hFD);
    drive(0, 0, 1);

    // Enable gaps; disabled samples carry 100 and must be ignored
    drive(4, 1, 1); drive(100, 0, 1); drive(4, 1, 1); drive(100, 0, 1);
    drive(100, 0, 1); drive(4, 1, 1);
    chk("gap_not_yet", int'(o_valid), 0);
    drive(4, 1, 1);
    chk("gap_valid", int'(o_valid), 1);
    chk("gap_data", int'(o_data), 4);
    drive(0, 0, 1);
    chk("gap_drained", int'(o_valid), 0);

    // Back-pressure and overrun
    for (int k = 0; k < 4; k++) drive(8, 1, 0);
    chk("bp_valid", int'(o_valid), 1);
    chk("bp_data", int'(o_data), 8);
    chk("bp_no_ovr_yet", int'(o_overrun), 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 0);
    chk("ovr_valid", int'(o_valid), 1);
    chk("ovr_data_kept", int'(o_data), 8);
    chk("ovr_flag", int'(o_overrun), 1);
    drive(0, 0, 1);
    chk("ovr_drained", int'(o_valid), 0);
    chk("ovr_data_hold", int'(o_data), 8);
    chk("ovr_sticky", int'(o_overrun), 1);

    // Back-to-back delivery
    for (int k = 0; k < 4; k++) drive(10, 1, 1);
    chk("b2b_first", int'(o_data), 10);
    chk("b2b_first_v", int'(o_valid), 1);
    drive(20, 1, 1);
    chk("b2b_gap_v", int'(o_valid), 0);
    for (int k = 0; k < 3; k++) drive(20, 1, 1);
    chk("b2b_second", int'(o_data), 20);
    chk("b2b_second_v", int'(o_valid), 1);
    drive(0, 0, 1);

    // Reset mid-block (also clears the sticky overrun)
    drive(7, 1, 1); drive(7, 1, 1); drive(7, 1, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_async_valid", int'(o_valid), 0);
    chk("rst_async_data", int'(o_data), 0);
    chk("rst_async_ovr", int'(o_overrun), 0);
    @(negedge clock);
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(1, 1, 1);
    chk("rst_block_valid", int'(o_valid), 1);
    chk("rst_block_data", int'(o_data), 1);
    drive(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
